crosspoint_prog: RTL and testbench

- Host-side serial programmer for the 48-output crosspoint. It drives that block's serial clock, data and clear pins.
- Accepts one route command per valid/ready handshake: output index, input select and connect value.
- Computes the matrix bit address, then serialises it as a clear pulse, 12 address bits LSB-first, then one data bit.
- Sits between the board controller's register logic and the crosspoint pins.

---
 rtl/crosspoint_prog.sv | 161 ++++++++++++++++
 tb/tb_crosspoint_prog.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crosspoint_prog.sv
// crosspoint_prog: serial programmer for the 48-output crosspoint matrix.
// Each accepted route command becomes a clear slot, 12 LSB-first address slots and one data slot.
module crosspoint_prog #(
  parameter int unsigned DIV = 2
) (
  input  logic       clk_,
  input  logic       rst_,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [5:0] cmd_out,
  input  logic [3:0] cmd_sel,
  input  logic       cmd_val,
  output logic       cmd_err,
  output logic       done,
  output logic       busy,
  output logic       xp_clk,
  output logic       xp_dat,
  output logic       xp_clear
);
  localparam int unsigned   PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PH_LAST   = PW'(DIV - 1);
  localparam logic [3:0]    SLOT_LAST = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_ADDR = 2'd2,
    S_DATA = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]    slot_q, slot_d;
  logic [11:0]   addr_q, addr_d;
  logic          val_q, val_d;
  logic          xp_clk_q, xp_clk_d;
  logic          xp_dat_q, xp_dat_d;
  logic          xp_clear_q, xp_clear_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  logic          cmd_legal;
  logic [11:0]   cmd_addr;
  logic [3:0]    slot_nxt;

  assign cmd_legal = (cmd_out < 6'd48) && (cmd_sel < 4'd9);
  assign cmd_addr  = (12'(cmd_out) * 12'd9) + 12'(cmd_sel);
  assign slot_nxt  = slot_q + 4'd1;

  // Next state: each half slot lasts DIV cycles; data/clear only change with the rising xp_clk.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    slot_d     = slot_q;
    addr_d     = addr_q;
    val_d      = val_q;
    xp_clk_d   = xp_clk_q;
    xp_dat_d   = xp_dat_q;
    xp_clear_d = xp_clear_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (state_q == S_IDLE) begin
      if (cmd_valid) begin
        if (cmd_legal) begin
          state_d    = S_CLR;
          addr_d     = cmd_addr;
          val_d      = cmd_val;
          phase_d    = {PW{1'b0}};
          slot_d     = 4'd0;
          xp_clk_d   = 1'b1;
          xp_dat_d   = 1'b0;
          xp_clear_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        phase_d = {PW{1'b0}};
      end
    end else if (phase_q != PH_LAST) begin
      phase_d = phase_q + PW'(1);
    end else if (xp_clk_q) begin
      phase_d  = {PW{1'b0}};
      xp_clk_d = 1'b0;
    end else begin
      // End of a slot: start the next one, or finish the frame.
      phase_d = {PW{1'b0}};
      case (state_q)
        S_CLR: begin
          state_d    = S_ADDR;
          slot_d     = 4'd0;
          xp_clk_d   = 1'b1;
          xp_clear_d = 1'b0;
          xp_dat_d   = addr_q[0];
        end
        S_ADDR: begin
          xp_clk_d = 1'b1;
          if (slot_q == SLOT_LAST) begin
            state_d  = S_DATA;
            slot_d   = 4'd0;
            xp_dat_d = val_q;
          end else begin
            slot_d   = slot_nxt;
            xp_dat_d = addr_q[slot_nxt];
          end
        end
        S_DATA: begin
          state_d    = S_IDLE;
          xp_clear_d = 1'b1;
          xp_dat_d   = 1'b0;
          done_d     = 1'b1;
        end
        default: begin
          state_d    = S_IDLE;
          xp_clk_d   = 1'b0;
          xp_clear_d = 1'b1;
          xp_dat_d   = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk_) begin
    if (!rst_) begin
      state_q    <= S_IDLE;
      phase_q    <= {PW{1'b0}};
      slot_q     <= 4'd0;
      addr_q     <= 12'd0;
      val_q      <= 1'b0;
      xp_clk_q   <= 1'b0;
      xp_dat_q   <= 1'b0;
      xp_clear_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      slot_q     <= slot_d;
      addr_q     <= addr_d;
      val_q      <= val_d;
      xp_clk_q   <= xp_clk_d;
      xp_dat_q   <= xp_dat_d;
      xp_clear_q <= xp_clear_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign cmd_err   = err_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign xp_clk    = xp_clk_q;
  assign xp_dat    = xp_dat_q;
  assign xp_clear  = xp_clear_q;

endmodule

// File: tb/tb_crosspoint_prog.sv
// tb_crosspoint_prog: three programmers (DIV=2,1,5) compared every cycle against a frame
// timeline model, with a bit-serial crosspoint model per instance checking the written matrix.
`timescale 1ns/1ps
module tb_crosspoint_prog;
  localparam int NI = 3;

  function automatic int div_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 5);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_v       [NI];
  logic         valid_v     [NI];
  logic [5:0]   out_v       [NI];
  logic [3:0]   sel_v       [NI];
  logic         val_v       [NI];
  logic         ready_w     [NI];
  logic         err_w       [NI];
  logic         done_w      [NI];
  logic         busy_w      [NI];
  logic         xclk_w      [NI];
  logic         xdat_w      [NI];
  logic         xclr_w      [NI];
  logic         fall_en     [NI];
  logic [431:0] ref_mat     [NI];
  logic         mat_ok      [NI];
  int           falls_a     [NI];
  logic [11:0]  last_addr_a [NI];
  logic         last_val_a  [NI];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[div=%0d] @%0t: got %0d, want %0d", name, div_of(g), $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

    crosspoint_prog #(.DIV(D)) dut (
      .clk_      (clk),
      .rst_      (rst_v[g]),
      .cmd_valid (valid_v[g]),
      .cmd_ready (ready_w[g]),
      .cmd_out   (out_v[g]),
      .cmd_sel   (sel_v[g]),
      .cmd_val   (val_v[g]),
      .cmd_err   (err_w[g]),
      .done      (done_w[g]),
      .busy      (busy_w[g]),
      .xp_clk    (xclk_w[g]),
      .xp_dat    (xdat_w[g]),
      .xp_clear  (xclr_w[g])
    );

    // Timeline model: m_k is the cycle number within the 28*D-cycle frame (1 = first CLR cycle).
    logic        m_on = 1'b0;
    logic        m_act, m_err, m_done, m_val;
    int          m_k;
    logic [11:0] m_addr;
    always @(posedge clk) begin
      if (!rst_v[g]) begin
        m_on <= 1'b1; m_act <= 1'b0; m_err <= 1'b0; m_done <= 1'b0; m_k <= 0;
      end else if (!m_act) begin
        m_done <= 1'b0;
        m_err  <= 1'b0;
        if (valid_v[g]) begin
          if (int'(out_v[g]) < 48 && int'(sel_v[g]) < 9) begin
            m_act  <= 1'b1;
            m_k    <= 1;
            m_addr <= 12'(int'(out_v[g]) * 9 + int'(sel_v[g]));
            m_val  <= val_v[g];
          end else begin
            m_err <= 1'b1;
          end
        end
      end else if (m_k == 28 * D) begin
        m_act  <= 1'b0;
        m_done <= 1'b1;
      end else begin
        m_k <= m_k + 1;
      end
    end

    // Compare every output on the falling system clock.
    always @(negedge clk) begin
      if (m_on) begin
        automatic int   s     = m_act ? (m_k - 1) / (2 * D) : 0;
        automatic int   ph    = m_act ? (m_k - 1) % (2 * D) : 0;
        automatic logic e_clk = m_act && (ph < D);
        automatic logic e_clr = !m_act || (s == 0);
        automatic logic e_dat = 1'b0;
        if (m_act && s >= 1 && s <= 12) e_dat = m_addr[s-1];
        else if (m_act && s == 13)      e_dat = m_val;
        chk("cmd_ready", g, ready_w[g], !m_act);
        chk("busy",      g, busy_w[g],  m_act);
        chk("done",      g, done_w[g],  m_done);
        chk("cmd_err",   g, err_w[g],   m_err);
        chk("xp_clk",    g, xclk_w[g],  e_clk);
        chk("xp_clear",  g, xclr_w[g],  e_clr);
        chk("xp_dat",    g, xdat_w[g],  e_dat);
      end
    end

    // Crosspoint: falling edge with clear resets the counter; 12 address bits, then the data bit.
    logic [431:0] mat       = '0;
    int           cnt       = 0;
    logic [11:0]  sh        = '0;
    int           falls     = 0;
    logic [11:0]  last_addr = '0;
    logic         last_val  = 1'b0;
    always @(negedge xclk_w[g]) begin
      if (fall_en[g]) begin
        falls <= falls + 1;
        if (xclr_w[g]) begin
          cnt <= 0;
        end else if (cnt < 12) begin
          sh[cnt] <= xdat_w[g];
          cnt     <= cnt + 1;
        end else if (cnt == 12) begin
          if (sh < 12'd432) mat[sh] <= xdat_w[g];
          last_addr <= sh;
          last_val  <= xdat_w[g];
          cnt       <= 13;
        end
      end
    end

    assign mat_ok[g]      = (mat == ref_mat[g]);
    assign falls_a[g]     = falls;
    assign last_addr_a[g] = last_addr;
    assign last_val_a[g]  = last_val;
  end

  task automatic send(input int g, input int o, input int s, input logic v, input bit hold, output int lat);
    automatic bit legal = (o < 48) && (s < 9);
    int n;
    out_v[g]   = 6'(o);
    sel_v[g]   = 4'(s);
    val_v[g]   = v;
    valid_v[g] = 1'b1;
    n = 0;
    while (!ready_w[g] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("ready_timeout", g, 32'd0, 32'd1);
    @(negedge clk);
    if (!hold) valid_v[g] = 1'b0;
    lat = 1;
    if (legal) begin
      ref_mat[g][o*9+s] = v;
      while (!done_w[g] && lat < 28 * div_of(g) + 20) begin
        @(negedge clk);
        lat++;
      end
      chk("latency", g, lat, 28 * div_of(g) + 1);
    end else begin
      chk("err_pulse", g, err_w[g], 32'd1);
    end
  endtask

  initial begin
    int lat;
    int f0;
    for (int u = 0; u < NI; u++) begin
      rst_v[u] = 1'b0; valid_v[u] = 1'b0; out_v[u] = 6'd0; sel_v[u] = 4'd0;
      val_v[u] = 1'b0; fall_en[u] = 1'b0; ref_mat[u] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_clear", 0, xclr_w[0],  32'd1);
    chk("rst_ready", 0, ready_w[0], 32'd1);
    chk("rst_clk",   0, xclk_w[0],  32'd0);
    chk("rst_busy",  0, busy_w[0],  32'd0);
    for (int u = 0; u < NI; u++) begin
      rst_v[u]   = 1'b1;
      fall_en[u] = 1'b1;
    end
    @(negedge clk);

    // out=0 sel=0 val=1: address 0, done 57 cycles after accept
    f0 = falls_a[0];
    send(0, 0, 0, 1'b1, 1'b0, lat);
    chk("t1_lat",   0, lat, 32'd57);
    chk("t1_falls", 0, falls_a[0] - f0, 32'd14);
    chk("t1_addr",  0, last_addr_a[0], 32'd0);
    chk("t1_val",   0, last_val_a[0], 32'd1);
    chk("t1_bit0",  0, gi[0].mat[0], 32'd1);

    // out=47 sel=8: highest address 431
    send(0, 47, 8, 1'b1, 1'b0, lat);
    chk("t2_addr",   0, last_addr_a[0], 32'd431);
    chk("t2_bit431", 0, gi[0].mat[431], 32'd1);

    // Out-of-range commands are dropped with an error pulse and no serial activity
    f0 = falls_a[0];
    send(0, 48, 0, 1'b1, 1'b0, lat);
    send(0, 3, 9, 1'b1, 1'b0, lat);
    repeat (4) @(negedge clk);
    chk("t3_falls", 0, falls_a[0] - f0, 32'd0);
    chk("t3_ready", 0, ready_w[0], 32'd1);

    // Back-to-back with valid held: address 11 set then cleared
    f0 = falls_a[0];
    send(0, 1, 2, 1'b1, 1'b1, lat);
    send(0, 1, 2, 1'b0, 1'b0, lat);
    chk("t4_falls", 0, falls_a[0] - f0, 32'd28);
    chk("t4_bit11", 0, gi[0].mat[11], 32'd0);

    // Reset during the low half of the 5th address slot of out=5 sel=5, then out=2 sel=1
    out_v[0] = 6'd5; sel_v[0] = 4'd5; val_v[0] = 1'b1; valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    repeat (22) @(negedge clk);
    rst_v[0] = 1'b0;
    @(negedge clk);
    chk("t5_clear", 0, xclr_w[0], 32'd1);
    chk("t5_clk",   0, xclk_w[0], 32'd0);
    rst_v[0] = 1'b1;
    @(negedge clk);
    send(0, 2, 1, 1'b1, 1'b0, lat);
    chk("t5_bit19", 0, gi[0].mat[19], 32'd1);
    chk("t5_bit50", 0, gi[0].mat[50], 32'd0);
    chk("t5_matrix", 0, mat_ok[0], 32'd1);

    // DIV=1 and DIV=5: random legal commands, one back-to-back pair each
    for (int u = 1; u < NI; u++) begin
      for (int i = 0; i < 8; i++) begin
        send(u, int'($urandom_range(0, 47)), int'($urandom_range(0, 8)),
             1'($urandom_range(0, 1)), (i == 3), lat);
      end
      repeat (2) @(negedge clk);
      chk("rand_matrix", u, mat_ok[u], 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
